// File: rtl/ofmap_glb_pkg.sv
// ofmap_glb_pkg: shared state type and sizing helpers for the ofmap GLB writer.
package ofmap_glb_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int DEF_PE_SIZE    = 14;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int ROW_WIDTH      = DEF_DATA_WIDTH * DEF_PE_SIZE;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/ofmap_row_fifo.sv
// ofmap_row_fifo: synchronous row FIFO; pointers carry a wrap bit so full and empty are distinct.
module ofmap_row_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 112
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end
    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end
    assign rdata = mem[rptr[AW-1:0]];
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
endmodule

// File: rtl/ofmap_glb_writer.sv
// ofmap_glb_writer: buffers accumulator ofmap rows and writes them to GLB at consecutive addresses.
// Define OFMAP_RELU_EN to clamp negative lanes to zero as rows are captured.
module ofmap_glb_writer
    import ofmap_glb_pkg::*;
#(
    parameter int PE_SIZE       = DEF_PE_SIZE,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = 16,
    parameter int OFMAP_ROW_NUM = 294,
    parameter int BUF_DEPTH     = 4
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [ADDR_WIDTH-1:0]         base_addr_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] ofmap_row_i,
    input  logic                          ofmap_valid_i,
    output logic                          glb_wren_o,
    output logic [ADDR_WIDTH-1:0]         glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    input  logic                          glb_ready_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o
);
    localparam int RW = DATA_WIDTH * PE_SIZE;
    localparam int CW = cnt_width(OFMAP_ROW_NUM);
    localparam logic [CW-1:0] LAST = CW'(OFMAP_ROW_NUM - 1);
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0] rows_in, rows_out;
    logic overflow, full, empty, push, pop, wren;
    logic [RW-1:0] row_st, head;
    assign wren = !empty && (state == RUN || state == DRAIN);
    assign pop  = wren && glb_ready_i;
    // A full buffer still accepts a row when the head leaves in the same cycle.
    assign push = state == RUN && ofmap_valid_i && (!full || pop);
`ifdef OFMAP_RELU_EN
    always_comb begin
        row_st = ofmap_row_i;
        for (int k = 0; k < PE_SIZE; k++)
            row_st[DATA_WIDTH*k +: DATA_WIDTH] = ofmap_row_i[DATA_WIDTH*k + DATA_WIDTH-1] ? '0 : ofmap_row_i[DATA_WIDTH*k +: DATA_WIDTH];
    end
`else
    assign row_st = ofmap_row_i;
`endif
    ofmap_row_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(RW)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .wdata(row_st), .rdata(head), .full(full), .empty(empty)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_i ? RUN : IDLE;
            RUN:     state_nx = (push && rows_in == LAST) ? DRAIN : RUN;
            DRAIN:   state_nx = (pop && rows_out == LAST) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            rows_in  <= '0;
            rows_out <= '0;
            overflow <= 1'b0;
        end else if (state == IDLE && start_i) begin
            addr     <= base_addr_i;
            rows_in  <= '0;
            rows_out <= '0;
            overflow <= 1'b0;
        end else begin
            if (ofmap_valid_i && !push) overflow <= 1'b1;
            if (push) rows_in <= rows_in + 1'b1;
            if (pop) begin
                addr     <= addr + 1'b1;
                rows_out <= rows_out + 1'b1;
            end
        end
    end
    assign glb_wren_o  = wren;
    assign glb_addr_o  = addr;
    assign glb_wdata_o = wren ? head : '0;
    assign busy_o      = state == RUN || state == DRAIN;
    assign done_o      = state == DONE;
    assign overflow_o  = overflow;
endmodule

// File: tb/tb_ofmap_glb_writer.sv
// tb_ofmap_glb_writer: vector table, directed corner sequences and random traffic against a queue model.
module tb_ofmap_glb_writer;
    localparam int PE = 14, DW = 8, AW = 16, N = 6, DEPTH = 4, RW = PE * DW, OW = 1 + AW + RW + 3;

    logic clk = 0, rst_n = 0, start_i = 0, ofmap_valid_i = 0, glb_ready_i = 0;
    logic [AW-1:0] base_addr_i = '0;
    logic [RW-1:0] ofmap_row_i = '0;
    logic glb_wren_o, busy_o, done_o, overflow_o;
    logic [AW-1:0] glb_addr_o;
    logic [RW-1:0] glb_wdata_o;
    logic [OW-1:0] dut_out;

    always #5 clk = ~clk;

    ofmap_glb_writer #(.PE_SIZE(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OFMAP_ROW_NUM(N), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .ofmap_row_i(ofmap_row_i), .ofmap_valid_i(ofmap_valid_i),
        .glb_wren_o(glb_wren_o), .glb_addr_o(glb_addr_o), .glb_wdata_o(glb_wdata_o),
        .glb_ready_i(glb_ready_i), .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o)
    );
    assign dut_out = {glb_wren_o, glb_addr_o, glb_wdata_o, busy_o, done_o, overflow_o};

    int checks = 0, passed = 0, done_seen = 0;

    // Reference model: a tile in progress, counts of accepted/written rows, and a queue of buffered rows.
    bit in_tile, done_pend, ovf;
    int acc, wr;
    logic [AW-1:0] maddr;
    logic [RW-1:0] q[$];

    typedef struct {
        bit st; logic [AW-1:0] base; bit v; logic [RW-1:0] row; bit rdy;
        bit wren; logic [AW-1:0] addr; logic [RW-1:0] data; bit busy; bit done;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [RW-1:0] store(input logic [RW-1:0] r);
        logic [RW-1:0] s = r;
`ifdef OFMAP_RELU_EN
        for (int j = 0; j < PE; j++) if (s[j*DW + DW-1]) s[j*DW +: DW] = '0;
`endif
        return s;
    endfunction

    function automatic logic [OW-1:0] model_out();
        bit w = in_tile && q.size() > 0;
        return {w, maddr, w ? q[0] : {RW{1'b0}}, in_tile, done_pend, ovf};
    endfunction

    task automatic model_reset();
        in_tile = 0; done_pend = 0; ovf = 0; acc = 0; wr = 0; maddr = '0; q.delete();
    endtask

    task automatic model_step(input bit st, input logic [AW-1:0] base, input bit v, input logic [RW-1:0] row, input bit rdy);
        bit pop = in_tile && q.size() > 0 && rdy;
        bit push = v && in_tile && acc < N && (q.size() < DEPTH || pop);
        bit idle = !in_tile && !done_pend;
        done_pend = 0;
        if (idle && st) begin
            in_tile = 1; acc = 0; wr = 0; ovf = 0; maddr = base;
        end else if (v && !push) ovf = 1;
        if (pop) begin
            void'(q.pop_front());
            maddr = maddr + 1'b1;
            wr++;
            if (wr == N) begin in_tile = 0; done_pend = 1; end
        end
        if (push) begin q.push_back(store(row)); acc++; end
    endtask

    task automatic cyc(input bit st, input logic [AW-1:0] base, input bit v, input logic [RW-1:0] row, input bit rdy);
        start_i = st; base_addr_i = base; ofmap_valid_i = v; ofmap_row_i = row; glb_ready_i = rdy;
        model_step(st, base, v, row, rdy);
        @(posedge clk); #1;
        check("cycle", dut_out, model_out());
        if (done_o) done_seen++;
    endtask

    function automatic logic [RW-1:0] mk_row(input int k);
        logic [RW-1:0] r;
        for (int j = 0; j < PE; j++) r[j*DW +: DW] = 8'((k * 16 + j) & 'h7F);
        return r;
    endfunction

    function automatic logic [RW-1:0] rnd_row();
        logic [127:0] t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[RW-1:0];
    endfunction

    initial begin
        logic [7:0] pat [4];
        logic [RW-1:0] relu_in, relu_exp;
        pat = '{8'h80, 8'hFF, 8'h00, 8'h7F};
        for (int j = 0; j < PE; j++) begin
            relu_in[j*DW +: DW] = pat[j % 4];
`ifdef OFMAP_RELU_EN
            relu_exp[j*DW +: DW] = (j % 4 == 3) ? 8'h7F : 8'h00;
`else
            relu_exp[j*DW +: DW] = pat[j % 4];
`endif
        end
        tbl[0] = '{1, 16'h0100, 0, '0, 1, 0, 16'h0100, '0, 1, 0};
        for (int k = 0; k < N; k++)
            tbl[k+1] = '{0, 16'h0000, 1, mk_row(k), 1, 1, 16'(256 + k), mk_row(k), 1, 0};
        tbl[7] = '{0, 16'h0000, 0, '0, 1, 0, 16'h0106, '0, 0, 1};
        tbl[8] = '{0, 16'h0000, 0, '0, 1, 0, 16'h0106, '0, 0, 0};

        model_reset();
        @(posedge clk); #1;
        check("reset", dut_out, '0);
        rst_n = 1;

        // Unstalled tile: each row written one cycle after capture, done the cycle after the last write.
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].st, tbl[i].base, tbl[i].v, tbl[i].row, tbl[i].rdy);
            check("table", dut_out, {tbl[i].wren, tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].done, 1'b0});
        end

        // GLB stalled for 10 cycles while the buffer fills to exactly DEPTH.
        done_seen = 0;
        cyc(1, 16'h0100, 0, '0, 0);
        for (int k = 0; k < 10; k++) cyc(0, 0, k < 4, rnd_row(), 0);
        check("stall_hold", OW'({glb_wren_o, glb_addr_o, overflow_o}), OW'({1'b1, 16'h0100, 1'b0}));
        for (int k = 0; k < 10; k++) cyc(0, 0, k < 2, rnd_row(), 1);
        check("stall_done", OW'(done_seen), OW'(1));

        // Fifth row into a full stalled buffer is dropped; the tile stays open until the count is made up.
        done_seen = 0;
        cyc(1, 16'h0A00, 0, '0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, rnd_row(), 0);
        check("ovf_set", OW'(overflow_o), OW'(1));
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, '0, 1);
        check("ovf_still_run", OW'({busy_o, glb_wren_o, done_seen[0], overflow_o}), OW'(4'b1001));
        for (int k = 0; k < 6; k++) cyc(0, 0, k < 2, rnd_row(), 1);
        check("ovf_done_sticky", OW'({done_seen[1:0], overflow_o}), OW'(3'b011));

        // Push and pop in the same cycle while full: accepted, no overflow.
        cyc(1, 16'hFFFE, 0, '0, 0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 1, rnd_row(), 0);
        cyc(0, 0, 1, rnd_row(), 1);
        check("full_simul", OW'(overflow_o), OW'(0));
        cyc(0, 0, 1, rnd_row(), 1);
        for (int k = 0; k < 6; k++) cyc(0, 0, 0, '0, 1);
        check("addr_wrap", OW'(glb_addr_o), OW'(16'h0004));

        // Stray row in IDLE, start clears overflow, second start ignored.
        cyc(0, 0, 1, rnd_row(), 1);
        check("idle_valid", OW'({glb_wren_o, overflow_o}), OW'(2'b01));
        cyc(1, 16'h0200, 0, '0, 1);
        check("start_clears", OW'(overflow_o), OW'(0));
        cyc(1, 16'h0300, 1, rnd_row(), 1);
        check("restart_ignored", OW'(glb_addr_o), OW'(16'h0200));
        for (int k = 0; k < 8; k++) cyc(0, 0, k < 5, rnd_row(), 1);

        // Lane sign handling, then an asynchronous reset mid-tile.
        cyc(1, 16'h0400, 0, '0, 0);
        cyc(0, 0, 1, relu_in, 0);
        check("relu_lanes", OW'(glb_wdata_o), OW'(relu_exp));
        cyc(0, 0, 1, rnd_row(), 0);
        #2 rst_n = 0;
        #1 check("reset_mid", dut_out, '0);
        model_reset();
        done_seen = 0;
        start_i = 0; ofmap_valid_i = 0; glb_ready_i = 1;
        @(posedge clk); #1 rst_n = 1;
        for (int k = 0; k < 8; k++) cyc(0, 0, 0, '0, 1);
        check("no_done_after_reset", OW'(done_seen), OW'(0));

        // Random traffic, including stray starts and overflows.
        for (int k = 0; k < 1500; k++) begin
            bit st = (!in_tile && !done_pend) ? ($urandom_range(3) == 0) : ($urandom_range(39) == 0);
            cyc(st, 16'($urandom), $urandom_range(9) < 6, rnd_row(), $urandom_range(9) < 7);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
